// File: rtl/axi4lite_lbus_master.sv
// AXI4-Lite slave port to lbus master slot bridge: one transaction in flight,
// read-modify-write for partial strobes, local request watchdog.
module axi4lite_lbus_master #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        lbus_m_req,
    output logic [29:0] lbus_m_addr,
    output logic        lbus_m_rw,
    output logic [31:0] lbus_m_wdata,
    input  logic [31:0] lbus_m_rdata,
    input  logic        lbus_m_ack,
    input  logic        lbus_m_err,
    output logic        to_evt
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RMW_RD = 3'd1,
        WR_REQ = 3'd2,
        RD_REQ = 3'd3,
        B_RSP  = 3'd4,
        R_RSP  = 3'd5
    } state_t;

    state_t        state_r;
    logic          wr_prio_r;
    logic          req_r;
    logic          rw_r;
    logic [29:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [3:0]    strb_r;
    logic [CW-1:0] wd_cnt_r;
    logic [1:0]    bresp_r;
    logic          bvalid_r;
    logic [31:0]   rdata_r;
    logic [1:0]    rresp_r;
    logic          rvalid_r;
    logic          to_evt_r;
    logic          grant_wr_s;
    logic          grant_rd_s;
    logic          timeout_s;
    logic          unused_addr_s;

    // Byte-wise merge of new write data over the word read back from lbus
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return res;
    endfunction

    // Grant selection in IDLE; on a tie, wr_prio_r alternates read and write
    always_comb begin
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        if (state_r == IDLE) begin
            if (s_axi_awvalid && s_axi_wvalid && s_axi_arvalid) begin
                grant_wr_s = wr_prio_r;
                grant_rd_s = ~wr_prio_r;
            end else begin
                grant_wr_s = s_axi_awvalid & s_axi_wvalid;
                grant_rd_s = s_axi_arvalid;
            end
        end else begin
            grant_wr_s = 1'b0;
            grant_rd_s = 1'b0;
        end
    end

    assign timeout_s     = (wd_cnt_r == CW'(TIMEOUT_CYC - 1));
    assign unused_addr_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Transaction sequencer, lbus request registers, watchdog and AXI responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            wr_prio_r <= 1'b0;
            req_r     <= 1'b0;
            rw_r      <= 1'b0;
            addr_r    <= 30'd0;
            wdata_r   <= 32'd0;
            strb_r    <= 4'd0;
            wd_cnt_r  <= '0;
            bresp_r   <= 2'b00;
            bvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
            rresp_r   <= 2'b00;
            rvalid_r  <= 1'b0;
            to_evt_r  <= 1'b0;
        end else begin
            to_evt_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_wr_s) begin
                        wr_prio_r <= 1'b0;
                        addr_r    <= s_axi_awaddr[31:2];
                        wdata_r   <= s_axi_wdata;
                        strb_r    <= s_axi_wstrb;
                        if (s_axi_wstrb == 4'hF) begin
                            req_r    <= 1'b1;
                            rw_r     <= 1'b1;
                            wd_cnt_r <= '0;
                            state_r  <= WR_REQ;
                        end else if (s_axi_wstrb == 4'h0) begin
                            bresp_r  <= RESP_OKAY;
                            bvalid_r <= 1'b1;
                            state_r  <= B_RSP;
                        end else begin
                            req_r    <= 1'b1;
                            rw_r     <= 1'b0;
                            wd_cnt_r <= '0;
                            state_r  <= RMW_RD;
                        end
                    end else if (grant_rd_s) begin
                        wr_prio_r <= 1'b1;
                        addr_r    <= s_axi_araddr[31:2];
                        req_r     <= 1'b1;
                        rw_r      <= 1'b0;
                        wd_cnt_r  <= '0;
                        state_r   <= RD_REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RMW_RD: begin
                    if (req_r && lbus_m_ack) begin
                        req_r <= 1'b0;
                        if (lbus_m_err) begin
                            bresp_r  <= RESP_SLVERR;
                            bvalid_r <= 1'b1;
                            state_r  <= B_RSP;
                        end else begin
                            // req stays low for one cycle before the write is raised
                            wdata_r <= merge_bytes(lbus_m_rdata, wdata_r, strb_r);
                            rw_r    <= 1'b1;
                            state_r <= WR_REQ;
                        end
                    end else if (req_r && timeout_s) begin
                        req_r    <= 1'b0;
                        to_evt_r <= 1'b1;
                        bresp_r  <= RESP_DECERR;
                        bvalid_r <= 1'b1;
                        state_r  <= B_RSP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + CW'(1);
                    end
                end
                WR_REQ: begin
                    if (!req_r) begin
                        req_r    <= 1'b1;
                        wd_cnt_r <= '0;
                    end else if (lbus_m_ack) begin
                        req_r    <= 1'b0;
                        bresp_r  <= lbus_m_err ? RESP_SLVERR : RESP_OKAY;
                        bvalid_r <= 1'b1;
                        state_r  <= B_RSP;
                    end else if (timeout_s) begin
                        req_r    <= 1'b0;
                        to_evt_r <= 1'b1;
                        bresp_r  <= RESP_DECERR;
                        bvalid_r <= 1'b1;
                        state_r  <= B_RSP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + CW'(1);
                    end
                end
                RD_REQ: begin
                    if (req_r && lbus_m_ack) begin
                        req_r    <= 1'b0;
                        rdata_r  <= lbus_m_rdata;
                        rresp_r  <= lbus_m_err ? RESP_SLVERR : RESP_OKAY;
                        rvalid_r <= 1'b1;
                        state_r  <= R_RSP;
                    end else if (req_r && timeout_s) begin
                        req_r    <= 1'b0;
                        to_evt_r <= 1'b1;
                        rdata_r  <= 32'd0;
                        rresp_r  <= RESP_DECERR;
                        rvalid_r <= 1'b1;
                        state_r  <= R_RSP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + CW'(1);
                    end
                end
                B_RSP: begin
                    if (s_axi_bready) begin
                        bvalid_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        bvalid_r <= 1'b1;
                    end
                end
                R_RSP: begin
                    if (s_axi_rready) begin
                        rvalid_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        rvalid_r <= 1'b1;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign s_axi_awready = grant_wr_s;
    assign s_axi_wready  = grant_wr_s;
    assign s_axi_arready = grant_rd_s;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rvalid  = rvalid_r;
    assign lbus_m_req    = req_r;
    assign lbus_m_addr   = addr_r;
    assign lbus_m_rw     = rw_r;
    assign lbus_m_wdata  = wdata_r;
    assign to_evt        = to_evt_r;

endmodule

// File: tb/tb_axi4lite_lbus_master.sv
// Directed bench for axi4lite_lbus_master: AXI stimulus, a hand-driven lbus
// slave and a response scoreboard of expected AXI results.
module tb_axi4lite_lbus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata, lb_rdata, lb_wdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        lb_req, lb_rw, lb_ack, lb_err, to_evt;
    logic [29:0] lb_addr;

    typedef struct {
        logic        is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    axi4lite_lbus_master #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .lbus_m_req(lb_req), .lbus_m_addr(lb_addr), .lbus_m_rw(lb_rw), .lbus_m_wdata(lb_wdata),
        .lbus_m_rdata(lb_rdata), .lbus_m_ack(lb_ack), .lbus_m_err(lb_err), .to_evt(to_evt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input bit wr, output int t0);
        int n = 0;
        #1;
        while (!(wr ? (awready && wready) : arready) && n < 50) begin
            tick();
            #1;
            n++;
        end
        chk(wr ? "aw_grant" : "ar_grant", 32'(wr ? (awready && wready) : arready), 32'd1);
        t0 = cyc;
        tick();
    endtask

    task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er, output int t0);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        exp_q.push_back('{is_rd: 1'b0, resp: er, data: 32'd0});
        wait_grant(1'b1, t0);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_rd(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed,
                          output int t0);
        araddr = a; arvalid = 1'b1;
        exp_q.push_back('{is_rd: 1'b1, resp: er, data: ed});
        wait_grant(1'b0, t0);
        arvalid = 1'b0;
    endtask

    task automatic serve(input int dly, input logic [31:0] rd, input logic er, input logic erw,
                         input logic [29:0] ea, input logic [31:0] ewd, input bit cwd);
        int n = 0;
        while (!lb_req && n < 50) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(lb_req), 32'd1);
        chk("req_rw", 32'(lb_rw), 32'(erw));
        chk("req_addr", 32'(lb_addr), 32'(ea));
        if (cwd) chk("req_wdata", lb_wdata, ewd);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("req_hold", 32'(lb_req), 32'd1);
        end
        lb_ack = 1'b1; lb_rdata = rd; lb_err = er;
        tick();
        lb_ack = 1'b0; lb_rdata = 32'd0; lb_err = 1'b0;
        chk("req_drop", 32'(lb_req), 32'd0);
    endtask

    task automatic get_rsp(output int tv);
        exp_t e;
        int   n = 0;
        while (!(bvalid || rvalid) && n < 100) begin
            tick();
            n++;
        end
        tv = cyc;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_kind", {30'd0, bvalid, rvalid}, e.is_rd ? 32'd1 : 32'd2);
            if (e.is_rd) begin
                chk("rresp", 32'(rresp), 32'(e.resp));
                chk("rdata", rdata, e.data);
            end else begin
                chk("bresp", 32'(bresp), 32'(e.resp));
            end
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        chk("valid_clear", {30'd0, bvalid, rvalid}, 32'd0);
    endtask

    initial begin
        int  t0, tv, n;
        bit  got_wr;
        rst = 1'b1;
        awaddr = 32'd0; wdata = 32'd0; wstrb = 4'd0; awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'd0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        lb_rdata = 32'd0; lb_ack = 1'b0; lb_err = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(lb_req), 32'd0);
        chk("rst_rw_addr", {1'b0, lb_rw, lb_addr}, 32'd0);
        chk("rst_wdata", lb_wdata, 32'd0);
        chk("rst_valids", {28'd0, bvalid, rvalid, to_evt, awready | arready | wready}, 32'd0);
        chk("rst_resp_rdata", rdata | 32'(bresp) | 32'(rresp), 32'd0);
        rst = 1'b0;
        tick();

        // full write, ack after 3 cycles
        axi_wr(32'h0000_1004, 32'hA5A5_5A5A, 4'hF, 2'b00, t0);
        chk("wr_req_t1", 32'(lb_req), 32'd1);
        serve(3, 32'd0, 1'b0, 1'b1, 30'h401, 32'hA5A5_5A5A, 1'b1);
        get_rsp(tv);
        chk("wr_latency", 32'(tv - t0), 32'd5);

        // plain read
        axi_rd(32'h0000_2008, 2'b00, 32'h1234_5678, t0);
        serve(1, 32'h1234_5678, 1'b0, 1'b0, 30'h802, 32'd0, 1'b0);
        get_rsp(tv);

        // partial-strobe write: read-modify-write
        axi_wr(32'h0000_3000, 32'hFFFF_BEEF, 4'b0011, 2'b00, t0);
        serve(2, 32'h1111_2222, 1'b0, 1'b0, 30'hC00, 32'd0, 1'b0);
        tick();
        chk("rmw_wr_req", {30'd0, lb_req, lb_rw}, 32'd3);
        serve(1, 32'd0, 1'b0, 1'b1, 30'hC00, 32'h1111_BEEF, 1'b1);
        get_rsp(tv);

        // empty strobe: OKAY without lbus access
        axi_wr(32'h0000_3004, 32'h5555_5555, 4'h0, 2'b00, t0);
        chk("nostrb_no_req", {30'd0, lb_req, bvalid}, 32'd1);
        get_rsp(tv);
        chk("nostrb_req_idle", 32'(lb_req), 32'd0);

        // contending channels alternate R,W,R,W
        awaddr = 32'h0000_5000; wdata = 32'hDEAD_0001; wstrb = 4'hF; araddr = 32'h0000_6000;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            #1;
            while (!(awready || arready) && n < 50) begin
                tick();
                #1;
                n++;
            end
            got_wr = awready;
            chk("alt_grant", 32'(got_wr), 32'(i % 2));
            chk("alt_req_low", 32'(lb_req), 32'd0);
            exp_q.push_back('{is_rd: !got_wr, resp: 2'b00, data: 32'h0000_00A0 + 32'(i)});
            tick();
            serve(1, 32'h0000_00A0 + 32'(i), 1'b0, got_wr, got_wr ? 30'h1400 : 30'h1800,
                  32'hDEAD_0001, got_wr);
            get_rsp(tv);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();

        // never acked read: local timeout
        axi_rd(32'h0000_4000, 2'b11, 32'd0, t0);
        n = 0;
        while (lb_req && n < 200) begin
            n++;
            tick();
        end
        chk("to_req_len", 32'(n), 32'd64);
        chk("to_evt_pulse", {30'd0, to_evt, rvalid}, 32'd3);
        tick();
        chk("to_evt_single", 32'(to_evt), 32'd0);
        lb_ack = 1'b1; lb_rdata = 32'hFFFF_FFFF;
        tick();
        lb_ack = 1'b0; lb_rdata = 32'd0;
        chk("stray_ack_rdata", rdata, 32'd0);
        get_rsp(tv);
        lb_ack = 1'b1;
        tick();
        lb_ack = 1'b0;
        chk("stray_ack_idle", {29'd0, lb_req, bvalid, rvalid}, 32'd0);

        // lbus error on full write
        axi_wr(32'h0000_9000, 32'h0BAD_0BAD, 4'hF, 2'b10, t0);
        serve(0, 32'd0, 1'b1, 1'b1, 30'h2400, 32'h0BAD_0BAD, 1'b1);
        get_rsp(tv);

        // lbus error on RMW read: no write issued
        axi_wr(32'h0000_8000, 32'h1234_5678, 4'b1000, 2'b10, t0);
        serve(0, 32'h9999_9999, 1'b1, 1'b0, 30'h2000, 32'd0, 1'b0);
        get_rsp(tv);
        tick();
        chk("rmw_err_no_wr", 32'(lb_req), 32'd0);

        // reset while request outstanding
        axi_rd(32'h0000_7000, 2'b00, 32'd0, t0);
        chk("pre_rst_req", 32'(lb_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_req", 32'(lb_req), 32'd0);
        exp_q.delete();
        tick();
        chk("rst_no_rsp", {30'd0, bvalid, rvalid}, 32'd0);
        rst = 1'b0;
        tick();
        axi_rd(32'h0000_7004, 2'b00, 32'h0702_DEAD, t0);
        serve(2, 32'h0702_DEAD, 1'b0, 1'b0, 30'h1C01, 32'd0, 1'b0);
        get_rsp(tv);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
